// File: rtl/dpram_pkg.sv
// Shared constants and state type for the dual-port RAM responder.
package dpram_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

endpackage

// File: rtl/dpram_array.sv
// Plain storage: one write port, one synchronous read port with enable, no reset.
module dpram_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  // Read-before-write; the core handles same-address forwarding.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dpram_core.sv
// Dual-port RAM responder: init sweep FSM, write-first forwarding, read latency pipeline
// and a saturating same-address collision counter.
module dpram_core
  import dpram_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic [15:0]       collision_cnt
);

  localparam logic [ADDR_W-1:0] PtrLast = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == PtrLast) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy = (state_q == ST_INIT);

  logic init_wr, run, rd_req, wr_req, coll;

  assign init_wr = !rst && (state_q == ST_INIT);
  assign run     = !rst && (state_q == ST_RUN);
  assign rd_req  = run && read;
  assign wr_req  = run && write;
  assign coll    = rd_req && wr_req && (wr_address == rd_address);

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign arr_we    = init_wr || wr_req;
  assign arr_waddr = init_wr ? ptr_q : wr_address;
  assign arr_wdata = init_wr ? INIT_VAL : data_in;

  dpram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (rd_req),
    .raddr (rd_address),
    .rdata (arr_rdata)
  );

  // Stage 1: array read register plus a forwarding bypass captured on the same edge.
  logic              fwd_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic              valid1_q;
  logic [DATA_W-1:0] stage1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      valid1_q   <= 1'b0;
    end else begin
      valid1_q <= rd_req;
      if (rd_req) begin
        fwd_q <= coll;
        if (coll) fwd_data_q <= data_in;
      end
    end
  end

  assign stage1_data = fwd_q ? fwd_data_q : arr_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_cnt <= '0;
    end else if (coll && (collision_cnt != 16'hFFFF)) begin
      collision_cnt <= collision_cnt + 16'd1;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] data2_q;
    logic              valid2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) data2_q <= stage1_data;
      end
    end

    assign data_out = data2_q;
    assign rd_valid = valid2_q;
  end else begin : g_lat1
    // The unreset array register is masked to zero until the first read after reset.
    logic zero_q;

    always_ff @(posedge clk) begin
      if (rst)         zero_q <= 1'b1;
      else if (rd_req) zero_q <= 1'b0;
    end

    assign data_out = zero_q ? '0 : stage1_data;
    assign rd_valid = valid1_q;
  end

endmodule

// File: tb/tb_dpram_core.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance share stimulus and are checked
// against hand-computed values.
module tb_dpram_core;

  logic        clk = 1'b0;
  logic        rst, read, write;
  logic [7:0]  wr_address, rd_address;
  logic [15:0] data_in;

  logic [15:0] d1_data, d2_data, d1_cnt, d2_cnt;
  logic        d1_valid, d2_valid, d1_busy, d2_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpram_core #(.RD_LAT(1)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .read          (read),
    .write         (write),
    .wr_address    (wr_address),
    .rd_address    (rd_address),
    .data_in       (data_in),
    .data_out      (d1_data),
    .rd_valid      (d1_valid),
    .busy          (d1_busy),
    .collision_cnt (d1_cnt)
  );

  dpram_core #(.RD_LAT(2)) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .read          (read),
    .write         (write),
    .wr_address    (wr_address),
    .rd_address    (rd_address),
    .data_in       (data_in),
    .data_out      (d2_data),
    .rd_valid      (d2_valid),
    .busy          (d2_busy),
    .collision_cnt (d2_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    write = 1'b1; wr_address = a; data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  // Issue one read; lat1 result shows after the sampling edge, lat2 one edge later.
  task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
    read = 1'b1; rd_address = a;
    @(negedge clk);
    read = 1'b0;
    chk({tag, "_v1"}, 32'(d1_valid), 32'd1);
    chk({tag, "_d1"}, 32'(d1_data), 32'(exp));
    chk({tag, "_v2_early"}, 32'(d2_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_v1_off"}, 32'(d1_valid), 32'd0);
    chk({tag, "_d1_hold"}, 32'(d1_data), 32'(exp));
    chk({tag, "_v2"}, 32'(d2_valid), 32'd1);
    chk({tag, "_d2"}, 32'(d2_data), 32'(exp));
  endtask

  // Wait out the init sweep, counting cycles with busy high; a stray rd_valid is an error.
  task automatic wait_init(input string tag);
    int n;
    int stray;
    n = 1;
    stray = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d1_valid || d2_valid) stray++;
      if (!d1_busy) break;
      n++;
    end
    write = 1'b0;
    chk({tag, "_busy_len"}, 32'(n), 32'd256);
    chk({tag, "_busy2"}, 32'(d2_busy), 32'd0);
    chk({tag, "_stray_valid"}, 32'(stray), 32'd0);
  endtask

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0;
    wr_address = '0; rd_address = '0; data_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(d1_busy), 32'd1);
    chk("rst_data1", 32'(d1_data), 32'd0);
    chk("rst_data2", 32'(d2_data), 32'd0);
    chk("rst_valid", 32'({d1_valid, d2_valid}), 32'd0);
    chk("rst_cnt", 32'(d1_cnt), 32'd0);

    // Release reset with a write held through the whole sweep; it must be ignored.
    rst = 1'b0;
    write = 1'b1; wr_address = 8'h05; data_in = 16'hBEEF;
    wait_init("init");

    do_read("rd00", 8'h00, 16'h0000);
    do_read("rd7f", 8'h7F, 16'h0000);
    do_read("rdff", 8'hFF, 16'h0000);
    do_read("rd05", 8'h05, 16'h0000);

    do_write(8'h10, 16'hA5A5);
    do_read("wr10", 8'h10, 16'hA5A5);

    // Same-address collision: write-first.
    do_write(8'h20, 16'h1111);
    write = 1'b1; wr_address = 8'h20; data_in = 16'h2222;
    read = 1'b1; rd_address = 8'h20;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("coll_v1", 32'(d1_valid), 32'd1);
    chk("coll_d1", 32'(d1_data), 32'h2222);
    chk("coll_cnt1", 32'(d1_cnt), 32'd1);
    chk("coll_cnt2", 32'(d2_cnt), 32'd1);
    @(negedge clk);
    chk("coll_d2", 32'(d2_data), 32'h2222);
    chk("coll_v2", 32'(d2_valid), 32'd1);

    // Different addresses in one cycle: old data, counter unchanged.
    write = 1'b1; wr_address = 8'h30; data_in = 16'h3333;
    read = 1'b1; rd_address = 8'h20;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("diff_d1", 32'(d1_data), 32'h2222);
    chk("diff_cnt", 32'(d1_cnt), 32'd1);
    @(negedge clk);
    chk("diff_d2", 32'(d2_data), 32'h2222);
    do_read("rd30", 8'h30, 16'h3333);

    // Streaming: mem[i] = i*3, then 256 back-to-back reads.
    for (int i = 0; i < 256; i++) do_write(8'(i), 16'(i * 3));
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) begin
        read = 1'b1; rd_address = 8'(i);
      end else begin
        read = 1'b0;
      end
      @(negedge clk);
      if (i < 256) begin
        chk("strm_v1", 32'(d1_valid), 32'd1);
        chk("strm_d1", 32'(d1_data), 32'(i * 3));
      end else begin
        chk("strm_v1_end", 32'(d1_valid), 32'd0);
      end
      if (i >= 1) begin
        chk("strm_v2", 32'(d2_valid), 32'd1);
        chk("strm_d2", 32'(d2_data), 32'((i - 1) * 3));
      end
    end
    read = 1'b0;
    @(negedge clk);
    chk("strm_v2_end", 32'(d2_valid), 32'd0);
    chk("strm_cnt", 32'(d1_cnt), 32'd1);

    // Reset with reads in flight.
    do_write(8'h40, 16'hCAFE);
    read = 1'b1; rd_address = 8'h40;
    @(negedge clk);
    chk("mid_pre_d1", 32'(d1_data), 32'hCAFE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; read = 1'b0;
    chk("mid_v1", 32'(d1_valid), 32'd0);
    chk("mid_v2", 32'(d2_valid), 32'd0);
    chk("mid_d1", 32'(d1_data), 32'd0);
    chk("mid_d2", 32'(d2_data), 32'd0);
    chk("mid_busy", 32'(d1_busy), 32'd1);
    chk("mid_cnt", 32'(d1_cnt), 32'd0);
    wait_init("reinit");
    do_read("rd40", 8'h40, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
